// File: rtl/button_sequence_capture_pkg.sv
// Shared constants, state encoding and helpers for the button sequence capture stage.
package button_sequence_capture_pkg;

  localparam int unsigned NUM_BUTTONS = 8;

  // One-hot difficulty level encodings.
  localparam logic [2:0] LV1 = 3'b001;
  localparam logic [2:0] LV2 = 3'b010;
  localparam logic [2:0] LV3 = 3'b100;

  // Sequence lengths per level.
  localparam logic [4:0] LEN_LV1 = 5'd8;
  localparam logic [4:0] LEN_LV2 = 5'd12;
  localparam logic [4:0] LEN_LV3 = 5'd16;

  // Cycles without a press before a capture gives up (10 s at 1 kHz).
  localparam int unsigned TIMEOUT_CYCLES = 10000;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_e;

  // Lowest set bit index; simultaneous presses resolve to the smallest button index.
  function automatic logic [2:0] lowest_index(input logic [NUM_BUTTONS-1:0] v);
    lowest_index = 3'd0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = i[2:0];
    end
  endfunction

endpackage

// File: rtl/button_sequence_capture_debouncer.sv
// Single-button debouncer: level follows raw only after it has differed for
// DEBOUNCE_CYCLES consecutive cycles; rise pulses for one cycle on a 0->1 change.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  // Count while raw disagrees with the debounced level; commit on the last count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (raw == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        level <= raw;
        rise  <= raw;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_sequence_capture.sv
// Button sequence capture: debounces 8 player buttons and records the index of each
// distinct press into up to 16 slots, sized by the one-hot level latched at start.
// Optional idle timeout in CAPTURE: define BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN.
module button_sequence_capture
  import button_sequence_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned MAX_LEN         = 16,
  parameter int unsigned IDX_W           = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [2:0]               level,
  input  logic [NUM_BUTTONS-1:0]   buttons,
  output logic [MAX_LEN*IDX_W-1:0] seq,
  output logic [4:0]               press_count,
  output logic [NUM_BUTTONS-1:0]   press_led,
`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
  output logic                     timeout,
`endif
  output logic                     end_signal
);

  state_e                 state;
  logic                   enable_q;
  logic [4:0]             target;
  logic [NUM_BUTTONS-1:0] deb_level;
  logic [NUM_BUTTONS-1:0] deb_rise;
  logic                   en_rise;
  logic                   level_ok;
  logic [4:0]             level_len;
  logic [IDX_W-1:0]       sel_idx;
  logic [NUM_BUTTONS-1:0] sel_onehot;

`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
  logic [13:0] idle_cnt;
  logic        to_hit;
`endif

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (buttons[i]),
      .level(deb_level[i]),
      .rise (deb_rise[i])
    );
  end

  // Decode start conditions and the winning press of this cycle.
  always_comb begin
    en_rise    = enable & ~enable_q;
    level_ok   = 1'b1;
    level_len  = LEN_LV1;
    unique case (level)
      LV1:     level_len = LEN_LV1;
      LV2:     level_len = LEN_LV2;
      LV3:     level_len = LEN_LV3;
      default: level_ok  = 1'b0;
    endcase
    sel_idx    = IDX_W'(lowest_index(deb_rise));
    sel_onehot = NUM_BUTTONS'(1) << sel_idx;
  end

  // Capture FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      enable_q    <= 1'b0;
      target      <= '0;
      seq         <= '0;
      press_count <= '0;
      press_led   <= '0;
      end_signal  <= 1'b0;
`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
      idle_cnt    <= '0;
      to_hit      <= 1'b0;
      timeout     <= 1'b0;
`endif
    end else begin
      enable_q <= enable;
      unique case (state)
        IDLE: begin
          if (en_rise && level_ok) begin
            target      <= level_len;
            seq         <= '0;
            press_count <= '0;
            press_led   <= '0;
            state       <= ARMED;
          end
        end
        ARMED: begin
          // Hold off until every button is released so pre-held buttons do not count.
          if (!enable) begin
            state <= IDLE;
          end else if (deb_level == '0) begin
            state <= CAPTURE;
`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        CAPTURE: begin
          if (!enable) begin
            state     <= IDLE;
            press_led <= '0;
          end else if (|deb_rise) begin
            seq[press_count[3:0]*IDX_W +: IDX_W] <= sel_idx;
            press_count <= press_count + 5'd1;
`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (press_count + 5'd1 == target) begin
              state     <= DONE;
              press_led <= '0;
            end else begin
              press_led <= sel_onehot;
            end
          end else begin
            press_led <= press_led & deb_level;
`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
            if (idle_cnt == 14'(TIMEOUT_CYCLES - 1)) begin
              state     <= DONE;
              to_hit    <= 1'b1;
              press_led <= '0;
            end else begin
              idle_cnt <= idle_cnt + 14'd1;
            end
`endif
          end
        end
        DONE: begin
          press_led <= '0;
          if (!enable) begin
            state      <= IDLE;
            end_signal <= 1'b0;
`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
            timeout    <= 1'b0;
            to_hit     <= 1'b0;
`endif
          end else begin
            end_signal <= 1'b1;
`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
            timeout    <= to_hit;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_sequence_capture.sv
// Directed bench for button_sequence_capture with hand-computed expectations.
module tb_button_sequence_capture;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  level;
  logic [7:0]  buttons;
  logic [47:0] seq;
  logic [4:0]  press_count;
  logic [7:0]  press_led;
  logic        end_signal;
`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;

  button_sequence_capture dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .level      (level),
    .buttons    (buttons),
    .seq        (seq),
    .press_count(press_count),
    .press_led  (press_led),
`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .end_signal (end_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Press button b (1..8): hold 30 cycles, release 30 cycles.
  task automatic press(input int b);
    buttons[b-1] = 1'b1;
    repeat (30) @(negedge clk);
    buttons[b-1] = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  // Wait up to budget cycles for press_count == n; reports cycles taken.
  task automatic wait_count(input int n, input int budget, output int cyc);
    cyc = budget;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (press_count == 5'(n)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic start(input logic [2:0] lv);
    level  = lv;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop();
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [47:0] pack(input int vals[16], input int n);
    logic [47:0] e;
    e = '0;
    for (int k = 0; k < n; k++) e[3*k +: 3] = 3'(vals[k]);
    return e;
  endfunction

  int cyc;
  int v1[16]  = '{2, 0, 7, 1, 1, 4, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0};
  int v3[16]  = '{5, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 0, 0, 0, 0};
  int v5[16]  = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int seq1[7] = '{3, 1, 8, 2, 2, 5, 7};
  int seq3[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 1, 2, 3};

  initial begin
    rst = 1'b0; enable = 1'b0; level = 3'b000; buttons = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_seq", seq, 48'h0);
    check_eq("rst_count", press_count, 5'd0);
    check_eq("rst_led", press_led, 8'h00);
    check_eq("rst_end", end_signal, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Invalid level must not start a capture.
    start(3'b011);
    press(1);
    check_eq("inv_level_count", press_count, 5'd0);
    stop();

    // Level 1: eight presses.
    start(3'b001);
    foreach (seq1[i]) press(seq1[i]);
    buttons[3] = 1'b1;
    wait_count(8, 40, cyc);
    check_eq("l1_count8", press_count, 5'd8);
    check_eq("l1_end_not_yet", end_signal, 1'b0);
    @(negedge clk);
    check_eq("l1_end_rise", end_signal, 1'b1);
    repeat (30) @(negedge clk);
    buttons[3] = 1'b0;
    repeat (30) @(negedge clk);
    press(6);
    check_eq("l1_seq", seq, pack(v1, 16));
    check_eq("l1_count_hold", press_count, 5'd8);
    check_eq("l1_end_held", end_signal, 1'b1);
    stop();
    check_eq("l1_end_cleared", end_signal, 1'b0);

    // Bounce on button 4, then hold.
    start(3'b001);
    for (int i = 0; i < 12; i++) begin
      buttons[3] = ~i[0];
      repeat (5) @(negedge clk);
    end
    check_eq("bounce_none", press_count, 5'd0);
    buttons[3] = 1'b1;
    wait_count(1, 40, cyc);
    check_eq("bounce_one", press_count, 5'd1);
    check_eq("bounce_latency", (cyc >= 20 && cyc <= 22), 1'b1);
    check_eq("bounce_slot", seq[2:0], 3'd3);
    check_eq("bounce_led", press_led, 8'h08);
    repeat (40) @(negedge clk);
    check_eq("bounce_only_one", press_count, 5'd1);
    stop();
    buttons = 8'h00;
    repeat (30) @(negedge clk);

    // Button 6 held across start, level 2.
    buttons[5] = 1'b1;
    repeat (30) @(negedge clk);
    start(3'b010);
    repeat (40) @(negedge clk);
    check_eq("held_no_record", press_count, 5'd0);
    buttons[5] = 1'b0;
    repeat (30) @(negedge clk);
    press(6);
    check_eq("held_first", press_count, 5'd1);
    foreach (seq3[i]) press(seq3[i]);
    check_eq("l2_count12", press_count, 5'd12);
    check_eq("l2_end", end_signal, 1'b1);
    check_eq("l2_seq", seq, pack(v3, 16));
    stop();

    // Buttons 2 and 5 debounce together.
    start(3'b001);
    buttons = 8'b0001_0010;
    wait_count(1, 40, cyc);
    check_eq("simul_slot", seq[2:0], 3'd1);
    check_eq("simul_led", press_led, 8'h02);
    repeat (10) @(negedge clk);
    check_eq("simul_count", press_count, 5'd1);
    buttons = 8'h00;
    repeat (30) @(negedge clk);
    check_eq("simul_led_off", press_led, 8'h00);
    stop();

    // Abort and restart at level 3.
    start(3'b100);
    for (int b = 1; b <= 5; b++) press(b);
    stop();
    check_eq("abort_end", end_signal, 1'b0);
    check_eq("abort_count", press_count, 5'd5);
    check_eq("abort_seq", seq, pack(v5, 16));
    enable = 1'b1;
    @(negedge clk);
    check_eq("restart_seq", seq, 48'h0);
    check_eq("restart_count", press_count, 5'd0);

    // Reset in the middle of the restarted capture.
    level = 3'b001;  // ignored once started
    for (int b = 1; b <= 3; b++) press(b);
    check_eq("pre_rst_count", press_count, 5'd3);
    buttons[6] = 1'b1;
    repeat (25) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_mid_seq", seq, 48'h0);
    check_eq("rst_mid_count", press_count, 5'd0);
    check_eq("rst_mid_led", press_led, 8'h00);
    check_eq("rst_mid_end", end_signal, 1'b0);
    buttons = 8'h00;
    enable  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

`ifdef BUTTON_SEQUENCE_CAPTURE_TIMEOUT_EN
    start(3'b001);
    press(2);
    for (int i = 0; i < 10100; i++) begin
      @(negedge clk);
      if (end_signal) break;
    end
    check_eq("to_end", end_signal, 1'b1);
    check_eq("to_flag", timeout, 1'b1);
    check_eq("to_count", press_count, 5'd1);
    check_eq("to_seq", seq, 48'h1);
    stop();
    check_eq("to_cleared", timeout, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
